dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port data-memory arbiter with one-cycle stores and two-cycle
//            loads that hold address/op stable while dmem extracts the data.
// Revision : 1.0 - initial release
// ============================================================================

package dmem_arbiter_pkg;
  typedef enum logic [2:0] {
    MEM_BYTE   = 3'd0,
    MEM_HALF   = 3'd1,
    MEM_WORD   = 3'd2,
    MEM_BYTE_U = 3'd4,
    MEM_HALF_U = 3'd5
  } mem_op_e;
endpackage

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter bit          RR_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            p0_req_valid,
  input  logic [XLEN-1:0] p0_req_addr,
  input  logic [XLEN-1:0] p0_req_wdata,
  input  logic            p0_req_we,
  input  mem_op_e         p0_req_op,
  output logic            p0_req_ready,
  output logic            p0_rsp_valid,
  output logic [XLEN-1:0] p0_rsp_rdata,

  input  logic            p1_req_valid,
  input  logic [XLEN-1:0] p1_req_addr,
  input  logic [XLEN-1:0] p1_req_wdata,
  input  logic            p1_req_we,
  input  mem_op_e         p1_req_op,
  output logic            p1_req_ready,
  output logic            p1_rsp_valid,
  output logic [XLEN-1:0] p1_rsp_rdata,

  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_wr_en,
  output logic            mem_rd_en,
  output mem_op_e         mem_op,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_HOLD = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            owner_q, owner_d;
  logic [XLEN-1:0] hold_addr_q, hold_addr_d;
  mem_op_e         hold_op_q, hold_op_d;
  logic [1:0]      rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_rdata0_q, rsp_rdata0_d;
  logic [XLEN-1:0] rsp_rdata1_q, rsp_rdata1_d;

  logic            grant;
  logic            accept;
  logic [XLEN-1:0] sel_addr;
  logic [XLEN-1:0] sel_wdata;
  logic            sel_we;
  mem_op_e         sel_op;

  // Grant is purely combinational; it only matters when some port is valid.
  always_comb begin
    grant = 1'b0;
    if (RR_EN) begin
      if (p0_req_valid && p1_req_valid) begin
        grant = ~last_q;
      end else begin
        grant = p1_req_valid;
      end
    end else begin
      grant = ~p0_req_valid;
    end
  end

  // rst_n gates acceptance so readys and mem_* drop immediately during reset.
  assign accept = rst_n && (state_q == IDLE) && (p0_req_valid || p1_req_valid);

  assign sel_addr  = grant ? p1_req_addr  : p0_req_addr;
  assign sel_wdata = grant ? p1_req_wdata : p0_req_wdata;
  assign sel_we    = grant ? p1_req_we    : p0_req_we;
  assign sel_op    = grant ? p1_req_op    : p0_req_op;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    owner_d      = owner_q;
    hold_addr_d  = hold_addr_q;
    hold_op_d    = hold_op_q;
    rsp_valid_d  = 2'b00;
    rsp_rdata0_d = rsp_rdata0_q;
    rsp_rdata1_d = rsp_rdata1_q;
    p0_req_ready = 1'b0;
    p1_req_ready = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wr_en    = 1'b0;
    mem_rd_en    = 1'b0;
    mem_op       = MEM_WORD;

    case (state_q)
      IDLE: begin
        if (accept) begin
          p0_req_ready = ~grant;
          p1_req_ready = grant;
          last_d       = grant;
          mem_addr     = sel_addr;
          mem_op       = sel_op;
          if (sel_we) begin
            mem_wr_en          = 1'b1;
            mem_wdata          = sel_wdata;
            rsp_valid_d[grant] = 1'b1;
            if (grant) begin
              rsp_rdata1_d = '0;
            end else begin
              rsp_rdata0_d = '0;
            end
          end else begin
            mem_rd_en   = 1'b1;
            hold_addr_d = sel_addr;
            hold_op_d   = sel_op;
            owner_d     = grant;
            state_d     = RD_HOLD;
          end
        end
      end

      RD_HOLD: begin
        // dmem extracts/sign-extends from the live addr/op, so re-drive them.
        mem_addr             = hold_addr_q;
        mem_op               = hold_op_q;
        mem_rd_en            = 1'b1;
        rsp_valid_d[owner_q] = 1'b1;
        if (owner_q) begin
          rsp_rdata1_d = mem_rdata;
        end else begin
          rsp_rdata0_d = mem_rdata;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      hold_addr_q  <= '0;
      hold_op_q    <= MEM_WORD;
      rsp_valid_q  <= 2'b00;
      rsp_rdata0_q <= '0;
      rsp_rdata1_q <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      hold_addr_q  <= hold_addr_d;
      hold_op_q    <= hold_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata0_q <= rsp_rdata0_d;
      rsp_rdata1_q <= rsp_rdata1_d;
    end
  end

  assign p0_rsp_valid = rsp_valid_q[0];
  assign p1_rsp_valid = rsp_valid_q[1];
  assign p0_rsp_rdata = rsp_rdata0_q;
  assign p1_rsp_rdata = rsp_rdata1_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Randomized bench for round-robin and fixed-priority arbiters
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v0 = 1'b0, v1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] a0 = '0, a1 = '0, wd0 = '0, wd1 = '0;
  mem_op_e     op0 = MEM_WORD, op1 = MEM_WORD;

  // Index 0: round-robin instance, index 1: fixed-priority instance.
  logic        rdy0 [2], rdy1 [2], rv0 [2], rv1 [2], mwe [2], mre [2];
  logic [31:0] rd0 [2], rd1 [2], maddr [2], mwd [2], mrd [2];
  mem_op_e     mop [2];

  logic [31:0] dm      [2][16];
  logic [31:0] ref_mem [2][16];

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter #(.XLEN(32), .RR_EN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(v0), .p0_req_addr(a0), .p0_req_wdata(wd0), .p0_req_we(we0), .p0_req_op(op0),
    .p0_req_ready(rdy0[0]), .p0_rsp_valid(rv0[0]), .p0_rsp_rdata(rd0[0]),
    .p1_req_valid(v1), .p1_req_addr(a1), .p1_req_wdata(wd1), .p1_req_we(we1), .p1_req_op(op1),
    .p1_req_ready(rdy1[0]), .p1_rsp_valid(rv1[0]), .p1_rsp_rdata(rd1[0]),
    .mem_addr(maddr[0]), .mem_wdata(mwd[0]), .mem_wr_en(mwe[0]), .mem_rd_en(mre[0]),
    .mem_op(mop[0]), .mem_rdata(mrd[0])
  );

  dmem_arbiter #(.XLEN(32), .RR_EN(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(v0), .p0_req_addr(a0), .p0_req_wdata(wd0), .p0_req_we(we0), .p0_req_op(op0),
    .p0_req_ready(rdy0[1]), .p0_rsp_valid(rv0[1]), .p0_rsp_rdata(rd0[1]),
    .p1_req_valid(v1), .p1_req_addr(a1), .p1_req_wdata(wd1), .p1_req_we(we1), .p1_req_op(op1),
    .p1_req_ready(rdy1[1]), .p1_rsp_valid(rv1[1]), .p1_rsp_rdata(rd1[1]),
    .mem_addr(maddr[1]), .mem_wdata(mwd[1]), .mem_wr_en(mwe[1]), .mem_rd_en(mre[1]),
    .mem_op(mop[1]), .mem_rdata(mrd[1])
  );

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                          input mem_op_e op);
    logic [31:0] sh;
    sh = word >> (8 * off);
    case (op)
      MEM_BYTE:   extract = {{24{sh[7]}}, sh[7:0]};
      MEM_BYTE_U: extract = {24'd0, sh[7:0]};
      MEM_HALF:   extract = {{16{sh[15]}}, sh[15:0]};
      MEM_HALF_U: extract = {16'd0, sh[15:0]};
      default:    extract = word;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] off,
                                        input mem_op_e op, input logic [31:0] wd);
    logic [31:0] mask;
    case (op)
      MEM_BYTE, MEM_BYTE_U: mask = 32'h0000_00FF << (8 * off);
      MEM_HALF, MEM_HALF_U: mask = 32'h0000_FFFF << (8 * off);
      default:              mask = 32'hFFFF_FFFF;
    endcase
    merge = (word & ~mask) | ((wd << (8 * off)) & mask);
  endfunction

  // Behavioural dmem: combinational extraction from the live addr/op.
  assign mrd[0] = extract(dm[0][maddr[0][5:2]], maddr[0][1:0], mop[0]);
  assign mrd[1] = extract(dm[1][maddr[1][5:2]], maddr[1][1:0], mop[1]);

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mwe[i]) dm[i][maddr[i][5:2]] = merge(dm[i][maddr[i][5:2]], maddr[i][1:0], mop[i], mwd[i]);
    end
  end

  task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: per instance, the pending load (if any), last winner,
  // and the response each port should show this cycle.
  bit          m_hold  [2];
  logic [31:0] m_haddr [2];
  mem_op_e     m_hop   [2];
  int          m_hport [2];
  logic [31:0] m_hdata [2];
  int          m_last  [2];
  logic        m_rv    [2][2];
  logic [31:0] m_rd    [2][2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_hold[i] = 1'b0; m_haddr[i] = '0; m_hop[i] = MEM_WORD; m_hport[i] = 0;
      m_hdata[i] = '0;  m_last[i] = 1;
      for (int p = 0; p < 2; p++) begin
        m_rv[i][p] = 1'b0; m_rd[i][p] = '0;
      end
    end
  endtask

  task automatic check_and_advance();
    for (int i = 0; i < 2; i++) begin
      string       pfx;
      int          w;
      logic        e_rdy0, e_rdy1, e_we, e_re;
      logic [31:0] e_addr, e_wd;
      mem_op_e     e_op;
      logic        s_we;
      pfx = (i == 0) ? "rr" : "fp";
      w = -1; e_rdy0 = 0; e_rdy1 = 0; e_we = 0; e_re = 0;
      e_addr = '0; e_wd = '0; e_op = MEM_WORD; s_we = 0;
      if (m_hold[i]) begin
        e_re = 1; e_addr = m_haddr[i]; e_op = m_hop[i];
      end else if (v0 || v1) begin
        if (i == 0 && v0 && v1) w = 1 - m_last[i];
        else                    w = v0 ? 0 : 1;
        e_rdy0 = (w == 0); e_rdy1 = (w == 1);
        e_addr = w ? a1 : a0; e_op = w ? op1 : op0; s_we = w ? we1 : we0;
        if (s_we) begin
          e_we = 1; e_wd = w ? wd1 : wd0;
        end else begin
          e_re = 1;
        end
      end
      check_eq({pfx, ".rdy0"}, 72'(rdy0[i]), 72'(e_rdy0));
      check_eq({pfx, ".rdy1"}, 72'(rdy1[i]), 72'(e_rdy1));
      check_eq({pfx, ".mem"}, 72'({mwe[i], mre[i], mop[i], maddr[i], mwd[i]}),
               72'({e_we, e_re, e_op, e_addr, e_wd}));
      check_eq({pfx, ".rv0"}, 72'(rv0[i]), 72'(m_rv[i][0]));
      check_eq({pfx, ".rv1"}, 72'(rv1[i]), 72'(m_rv[i][1]));
      check_eq({pfx, ".rd0"}, 72'(rd0[i]), 72'(m_rd[i][0]));
      check_eq({pfx, ".rd1"}, 72'(rd1[i]), 72'(m_rd[i][1]));

      m_rv[i][0] = 1'b0; m_rv[i][1] = 1'b0;
      if (m_hold[i]) begin
        m_rv[i][m_hport[i]] = 1'b1;
        m_rd[i][m_hport[i]] = m_hdata[i];
        m_hold[i] = 1'b0;
      end else if (w >= 0) begin
        m_last[i] = w;
        if (s_we) begin
          m_rv[i][w] = 1'b1;
          m_rd[i][w] = '0;
          ref_mem[i][e_addr[5:2]] = merge(ref_mem[i][e_addr[5:2]], e_addr[1:0], e_op, e_wd);
        end else begin
          m_hold[i]  = 1'b1;
          m_haddr[i] = e_addr;
          m_hop[i]   = e_op;
          m_hport[i] = w;
          m_hdata[i] = extract(ref_mem[i][e_addr[5:2]], e_addr[1:0], e_op);
        end
      end
    end
  endtask

  task automatic run(input logic iv0, input logic [31:0] ia0, input logic iwe0,
                     input mem_op_e iop0, input logic [31:0] iwd0,
                     input logic iv1, input logic [31:0] ia1, input logic iwe1,
                     input mem_op_e iop1, input logic [31:0] iwd1);
    @(posedge clk);
    #1;
    v0 = iv0; a0 = ia0; we0 = iwe0; op0 = iop0; wd0 = iwd0;
    v1 = iv1; a1 = ia1; we1 = iwe1; op1 = iop1; wd1 = iwd1;
    @(negedge clk);
    check_and_advance();
  endtask

  task automatic idle();
    run(0, 0, 0, MEM_WORD, 0, 0, 0, 0, MEM_WORD, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq({tag, ".rdy"}, 72'({rdy0[i], rdy1[i]}), 72'(0));
      check_eq({tag, ".rsp"}, 72'({rv0[i], rv1[i], rd0[i], rd1[i]}), 72'(0));
      check_eq({tag, ".mem"}, 72'({mwe[i], mre[i], mop[i], maddr[i], mwd[i]}),
               72'({1'b0, 1'b0, MEM_WORD, 32'd0, 32'd0}));
    end
  endtask

  function automatic mem_op_e rand_op();
    case ($urandom % 5)
      0:       rand_op = MEM_BYTE;
      1:       rand_op = MEM_HALF;
      2:       rand_op = MEM_WORD;
      3:       rand_op = MEM_BYTE_U;
      default: rand_op = MEM_HALF_U;
    endcase
  endfunction

  function automatic logic [31:0] rand_addr(input mem_op_e op);
    logic [1:0] off;
    off = 2'($urandom % 4);
    if (op == MEM_WORD) off = 2'b00;
    else if (op == MEM_HALF || op == MEM_HALF_U) off[0] = 1'b0;
    rand_addr = {26'd0, 4'($urandom % 16), off};
  endfunction

  initial begin
    logic [31:0] word;
    for (int w = 0; w < 16; w++) begin
      word = $urandom;
      if (w == 4) word = 32'h8000_00FF;
      for (int i = 0; i < 2; i++) begin
        dm[i][w] = word; ref_mem[i][w] = word;
      end
    end
    model_reset();

    // Reset holds everything idle even with requests pending.
    v0 = 1; v1 = 1; we0 = 1; we1 = 0; a0 = 32'h20; a1 = 32'h24;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("rst");
    v0 = 0; v1 = 0; we0 = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single LW, then LB with sign extension on the same word.
    run(1, 32'h10, 0, MEM_WORD, 0, 0, 0, 0, MEM_WORD, 0);
    idle();
    idle();
    check_eq("lw_data", 72'(rd0[0]), 72'(32'h8000_00FF));
    run(1, 32'h13, 0, MEM_BYTE, 0, 0, 0, 0, MEM_WORD, 0);
    idle();
    idle();
    check_eq("lb_data", 72'(rd0[0]), 72'(32'hFFFF_FF80));

    // Continuous stores on both ports, including unsigned-op stores.
    for (int k = 0; k < 8; k++)
      run(1, 32'h20 + 32'(4 * k), 1, (k % 2) ? MEM_BYTE_U : MEM_WORD, $urandom,
          1, 32'h24 + 32'(4 * k), 1, (k % 3 == 0) ? MEM_HALF_U : MEM_WORD, $urandom);

    // Load on port 0 racing a store on port 1.
    idle();
    for (int k = 0; k < 4; k++)
      run(1, 32'h18, 0, MEM_WORD, 0, 1, 32'h1C, 1, MEM_WORD, 32'hA5A5_0000 + 32'(k));

    // Mid-load reset: no response escapes and port 0 wins afterwards.
    idle();
    run(1, 32'h10, 0, MEM_WORD, 0, 0, 0, 0, MEM_WORD, 0);
    @(posedge clk);
    #1;
    v0 = 0; v1 = 0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    check_reset_outputs("midrst2");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run(1, 32'h30, 1, MEM_WORD, 32'h1234_5678, 1, 32'h34, 1, MEM_WORD, 32'h9ABC_DEF0);
    run(1, 32'h30, 1, MEM_WORD, 32'h1111_2222, 1, 32'h34, 1, MEM_WORD, 32'h3333_4444);

    // Randomized traffic on both instances.
    for (int k = 0; k < 600; k++) begin
      mem_op_e ro0, ro1;
      ro0 = rand_op(); ro1 = rand_op();
      run(($urandom % 4) != 0, rand_addr(ro0), 1'($urandom % 2), ro0, $urandom,
          ($urandom % 4) != 0, rand_addr(ro1), 1'($urandom % 2), ro1, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
